pe_array_ctrl: RTL and testbench

- Sequencer for an N x N weight-stationary systolic array of multiply-accumulate PEs.
- Each PE forwards weight/ifmap/psum and their enables to its neighbours with one register stage, and has a one-cycle product register before the accumulate.
- This block drives the array-edge enables with the required diagonal skew: weight_en on the top edge, ifmap_en on the left edge, psum_en on the top edge.
- It also issues read strobes/indices to the weight and ifmap buffers, and flags when each column's psum leaves the bottom edge.
- One job = load N weight rows, stream num_vec ifmap vectors, drain.

---
 rtl/pe_array_ctrl_pkg.sv | 29 ++
 rtl/pe_array_ctrl_if.sv | 33 +++
 rtl/pe_array_ctrl_skew.sv | 39 +++
 rtl/pe_array_ctrl.sv | 149 ++++++++++++++
 tb/tb_pe_array_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and derived constants for the systolic-array sequencer.
// The helper functions let each instance derive its own widths from its parameters.
package pe_array_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int ARRAY_SIZE_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int RES_LAT_DEF    = ARRAY_SIZE_DEF + 1;

    function automatic int row_w(input int n);
        return $clog2(n);
    endfunction

    // Drain must outlast the deepest out_valid tap (last column of the last vector).
    function automatic int drain_cyc(input int res_lat, input int n);
        return res_lat + n - 1;
    endfunction

    localparam int ROW_W     = row_w(ARRAY_SIZE_DEF);
    localparam int DRAIN_CYC = drain_cyc(RES_LAT_DEF, ARRAY_SIZE_DEF);

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Job-control and array-edge bundle between the sequencer (slave) and its user (master).
interface pe_array_ctrl_if #(
    parameter int ARRAY_SIZE = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int ROW_W = $clog2(ARRAY_SIZE);

    logic                  start_i;
    logic                  abort_i;
    logic [CNT_WIDTH-1:0]  num_vec_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  weight_rd_en_o;
    logic [ROW_W-1:0]      weight_row_o;
    logic                  ifmap_rd_en_o;
    logic [CNT_WIDTH-1:0]  ifmap_idx_o;
    logic [ARRAY_SIZE-1:0] weight_en_o;
    logic [ARRAY_SIZE-1:0] ifmap_en_o;
    logic [ARRAY_SIZE-1:0] psum_en_o;
    logic [ARRAY_SIZE-1:0] out_valid_o;

    modport master (
        output start_i, abort_i, num_vec_i,
        input  busy_o, done_o, weight_rd_en_o, weight_row_o, ifmap_rd_en_o,
               ifmap_idx_o, weight_en_o, ifmap_en_o, psum_en_o, out_valid_o
    );

    modport slave (
        input  start_i, abort_i, num_vec_i,
        output busy_o, done_o, weight_rd_en_o, weight_row_o, ifmap_rd_en_o,
               ifmap_idx_o, weight_en_o, ifmap_en_o, psum_en_o, out_valid_o
    );
endinterface

// File: rtl/pe_array_ctrl_skew.sv
// 1-bit tapped delay line: taps_o[i] is din_i delayed by (DEPTH-NTAPS+i+1) cycles.
// flush_i clears every stage on the next edge.
module skew_shift #(
    parameter int DEPTH = 4,
    parameter int NTAPS = DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             din_i,
    output logic [NTAPS-1:0] taps_o
);
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift one stage per cycle, or empty the line on flush.
    always_comb begin
        sr_d = {DEPTH{1'b0}};
        if (flush_i) begin
            sr_d = {DEPTH{1'b0}};
        end else begin
            sr_d[0] = din_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    // Delay-line storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {DEPTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign taps_o = sr_q[DEPTH-1 -: NTAPS];
endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array: loads weights,
// streams ifmap vectors with diagonal skew, drains, and flags bottom-edge psums.
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int RES_LAT    = ARRAY_SIZE + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pe_array_ctrl_if.slave   bus
);
    localparam int ROW_BITS  = row_w(ARRAY_SIZE);
    localparam int DRAIN_LEN = drain_cyc(RES_LAT, ARRAY_SIZE);

    state_e                state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  drain_q, drain_d;
    logic [CNT_WIDTH-1:0]  num_vec_q, num_vec_d;
    logic                  abort_s, stream_act_s;
    logic [ARRAY_SIZE-2:0] lane_taps_s;
    logic [ARRAY_SIZE-1:0] ov_taps_s;
    logic                  busy_s, done_s, wrd_s, ird_s;
    logic [ROW_BITS-1:0]   wrow_s;
    logic [CNT_WIDTH-1:0]  iidx_s;
    logic [ARRAY_SIZE-1:0] wen_s;

    assign abort_s = bus.abort_i && (state_q != IDLE);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= {ROW_BITS{1'b0}};
            idx_q     <= {CNT_WIDTH{1'b0}};
            drain_q   <= {CNT_WIDTH{1'b0}};
            num_vec_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            num_vec_q <= num_vec_d;
        end
    end

    // Next-state and counter update; abort outranks every other transition.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        num_vec_d = num_vec_q;
        if (abort_s) begin
            state_d = IDLE;
            row_d   = {ROW_BITS{1'b0}};
            idx_d   = {CNT_WIDTH{1'b0}};
            drain_d = {CNT_WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        num_vec_d = bus.num_vec_i;
                        state_d   = (bus.num_vec_i == {CNT_WIDTH{1'b0}}) ? DONE : LOAD_W;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD_W: begin
                    if (row_q == ROW_BITS'(ARRAY_SIZE - 1)) begin
                        row_d   = {ROW_BITS{1'b0}};
                        state_d = STREAM;
                    end else begin
                        row_d = row_q + ROW_BITS'(1);
                    end
                end
                // Compare against num_vec-1 so the index never has to reach num_vec.
                STREAM: begin
                    if (idx_q == num_vec_q - CNT_WIDTH'(1)) begin
                        idx_d   = {CNT_WIDTH{1'b0}};
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + CNT_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == CNT_WIDTH'(DRAIN_LEN - 1)) begin
                        drain_d = {CNT_WIDTH{1'b0}};
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q + CNT_WIDTH'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the state register only.
    always_comb begin
        busy_s       = 1'b1;
        done_s       = 1'b0;
        wrd_s        = 1'b0;
        wrow_s       = {ROW_BITS{1'b0}};
        wen_s        = {ARRAY_SIZE{1'b0}};
        ird_s        = 1'b0;
        iidx_s       = {CNT_WIDTH{1'b0}};
        stream_act_s = 1'b0;
        case (state_q)
            IDLE:   busy_s = 1'b0;
            LOAD_W: begin
                wrd_s  = 1'b1;
                wrow_s = row_q;
                wen_s  = {ARRAY_SIZE{1'b1}};
            end
            STREAM: begin
                ird_s        = 1'b1;
                iidx_s       = idx_q;
                stream_act_s = 1'b1;
            end
            DRAIN:   busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    skew_shift #(.DEPTH(ARRAY_SIZE - 1), .NTAPS(ARRAY_SIZE - 1)) u_lane_skew (
        .clk(clk), .rst_n(rst_n), .flush_i(abort_s), .din_i(stream_act_s), .taps_o(lane_taps_s)
    );

    // Only the last N stages matter: column c sees its psum RES_LAT+c cycles late.
    skew_shift #(.DEPTH(DRAIN_LEN), .NTAPS(ARRAY_SIZE)) u_ov_skew (
        .clk(clk), .rst_n(rst_n), .flush_i(abort_s), .din_i(stream_act_s), .taps_o(ov_taps_s)
    );

    assign bus.busy_o         = busy_s;
    assign bus.done_o         = done_s;
    assign bus.weight_rd_en_o = wrd_s;
    assign bus.weight_row_o   = wrow_s;
    assign bus.weight_en_o    = wen_s;
    assign bus.ifmap_rd_en_o  = ird_s;
    assign bus.ifmap_idx_o    = iidx_s;
    assign bus.ifmap_en_o     = {lane_taps_s, stream_act_s};
    assign bus.psum_en_o      = {lane_taps_s, stream_act_s};
    assign bus.out_valid_o    = ov_taps_s;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl at N=4, RES_LAT=5; per-cycle expectations come
// from the job timeline (load N, stream num_vec, drain 2N, done).
module tb_pe_array_ctrl;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int RL = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cur_t  = 0;

    pe_array_ctrl_if #(.ARRAY_SIZE(N), .CNT_WIDTH(CW)) bus ();

    pe_array_ctrl #(.ARRAY_SIZE(N), .CNT_WIDTH(CW), .RES_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s t=%0d: got %h, want %h", tag, cur_t, obs, exp);
        end
    endtask

    function automatic int job_len(input int nv);
        return (nv == 0) ? 1 : 3 * N + nv + 1;
    endfunction

    function automatic bit strm(input int nv, input int t);
        return (nv > 0) && (t >= N + 1) && (t <= N + nv);
    endfunction

    // Cycle t counts from 1 right after the accepting edge; t=0 means plain idle.
    task automatic check_cycle(input int nv, input int t);
        logic [N-1:0] ie;
        logic [N-1:0] ov;
        logic         ld;
        logic         st;
        logic         bz;
        logic         dn;
        int           tot;
        tot = job_len(nv);
        ld  = (nv > 0) && (t >= 1) && (t <= N);
        st  = strm(nv, t);
        bz  = (t >= 1) && (t <= tot);
        dn  = (t == tot);
        for (int i = 0; i < N; i++) begin
            ie[i] = strm(nv, t - i);
            ov[i] = strm(nv, t - RL - i);
        end
        cur_t = t;
        chk_vec("ctl", 32'({bus.busy_o, bus.done_o}), 32'({bz, dn}));
        chk_vec("wt", 32'({bus.weight_rd_en_o, bus.weight_row_o, bus.weight_en_o}),
                32'({ld, (ld ? 2'(t - 1) : 2'd0), (ld ? 4'hF : 4'h0)}));
        chk_vec("if", 32'({bus.ifmap_rd_en_o, bus.ifmap_idx_o}),
                32'({st, (st ? 16'(t - N - 1) : 16'd0)}));
        chk_vec("skew", 32'({bus.ifmap_en_o, bus.psum_en_o}), 32'({ie, ie}));
        chk_vec("ov", 32'(bus.out_valid_o), 32'(ov));
    endtask

    task automatic check_job(input int nv);
        for (int t = 1; t <= job_len(nv) + 1; t++) begin
            check_cycle(nv, t);
            if (t <= job_len(nv)) tick();
        end
    endtask

    task automatic start_job(input int nv);
        bus.num_vec_i = CW'(nv);
        bus.start_i   = 1'b1;
        tick();
        bus.start_i   = 1'b0;
    endtask

    initial begin
        int rd_cnt;
        int done_at;
        int t;
        logic [CW-1:0] last_idx;

        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.num_vec_i = '0;
        tick();
        tick();
        check_cycle(0, 0);
        rst_n = 1'b1;
        tick();

        // Baseline job, zero-length job, single-vector job.
        start_job(3);
        check_job(3);
        start_job(0);
        check_job(0);
        start_job(1);
        check_job(1);

        // Abort in the 2nd STREAM cycle with start re-pulsed alongside it.
        start_job(3);
        for (int k = 1; k <= 6; k++) begin
            check_cycle(3, k);
            if (k < 6) tick();
        end
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check_cycle(0, 0);
            tick();
        end
        // Abort alongside start in IDLE: start wins.
        bus.abort_i = 1'b1;
        start_job(1);
        bus.abort_i = 1'b0;
        check_job(1);

        // Abort during DONE: the done pulse still shows, then idle.
        start_job(0);
        bus.abort_i = 1'b1;
        check_cycle(0, 1);
        tick();
        bus.abort_i = 1'b0;
        check_cycle(0, 0);

        // Asynchronous reset in mid-STREAM, between clock edges.
        start_job(3);
        for (int k = 1; k <= 6; k++) begin
            check_cycle(3, k);
            if (k < 6) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_cycle(0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_cycle(0, 0);
        start_job(3);
        check_job(3);

        // start held high through a job: ignored while busy, restarts after DONE.
        bus.num_vec_i = 16'd2;
        bus.start_i   = 1'b1;
        tick();
        check_job(2);
        tick();
        bus.start_i = 1'b0;
        check_job(2);

        // Largest count must finish with no index wrap.
        start_job(65535);
        rd_cnt   = 0;
        done_at  = 0;
        last_idx = '0;
        t        = 1;
        while ((t < 70000) && (done_at == 0)) begin
            if (bus.ifmap_rd_en_o) begin
                rd_cnt++;
                last_idx = bus.ifmap_idx_o;
            end
            if (bus.done_o) done_at = t;
            tick();
            t++;
        end
        cur_t = t;
        chk_vec("max_rd", 32'(rd_cnt), 32'd65535);
        chk_vec("max_idx", 32'(last_idx), 32'h0000_FFFE);
        chk_vec("max_len", 32'(done_at), 32'd65548);
        check_cycle(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
